// File: rtl/ball_speed_sched_if.sv
// Event/speed bundle between game logic (master) and the ball speed scheduler (slave).
interface ball_speed_sched_if #(
    parameter int unsigned FREQ_W = 10
);
    logic              frame_tick;
    logic              start;
    logic              paddle_hit;
    logic              goal;
    logic              pause;
    logic [FREQ_W-1:0] strobe_freq;
    logic              move_en;
    logic [1:0]        state;
    logic [7:0]        hit_count;

    modport master (
        output frame_tick, start, paddle_hit, goal, pause,
        input  strobe_freq, move_en, state, hit_count
    );

    modport slave (
        input  frame_tick, start, paddle_hit, goal, pause,
        output strobe_freq, move_en, state, hit_count
    );
endinterface

// File: rtl/ball_speed_sched.sv
// Ball speed scheduler: sequences serve/play/pause and ramps the strobe frequency
// on paddle hits and during long rallies. All outputs are registered.
module ball_speed_sched #(
    parameter int unsigned FREQ_W      = 10,
    parameter int unsigned FREQ_START  = 60,
    parameter int unsigned FREQ_MAX    = 600,
    parameter int unsigned FREQ_STEP   = 20,
    parameter int unsigned SERVE_TICKS = 120,
    parameter int unsigned RAMP_TICKS  = 300
) (
    input  logic               clk,
    input  logic               rst,
    ball_speed_sched_if.slave  bus
);
    localparam int unsigned SERVE_W = (SERVE_TICKS > 1) ? $clog2(SERVE_TICKS + 1) : 1;
    localparam int unsigned RAMP_W  = (RAMP_TICKS > 1) ? $clog2(RAMP_TICKS + 1) : 1;

    localparam logic [FREQ_W:0]    FreqMaxW   = (FREQ_W + 1)'(FREQ_MAX);
    localparam logic [FREQ_W:0]    FreqStepW  = (FREQ_W + 1)'(FREQ_STEP);
    localparam logic [FREQ_W-1:0]  FreqMax    = FREQ_W'(FREQ_MAX);
    localparam logic [FREQ_W-1:0]  FreqStart  = FREQ_W'(FREQ_START);
    localparam logic [SERVE_W-1:0] ServeLoad  = SERVE_W'(SERVE_TICKS);
    localparam logic [SERVE_W-1:0] ServeOne   = SERVE_W'(1);

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StServe = 2'd1,
        StPlay  = 2'd2,
        StPause = 2'd3
    } state_e;

    state_e             state_q;
    logic [FREQ_W-1:0]  freq_q;
    logic [FREQ_W-1:0]  saved_freq_q;
    logic               move_en_q;
    logic [7:0]         hit_count_q;
    logic [SERVE_W-1:0] serve_cnt_q;
    logic [RAMP_W-1:0]  ramp_cnt_q;

    logic [FREQ_W:0]    hit_sum;
    logic [FREQ_W:0]    ramp_sum;
    logic [FREQ_W-1:0]  hit_freq;
    logic [FREQ_W-1:0]  ramp_freq;
    logic               ramp_done;

    // One extra bit of headroom so the clamp sees the true sum before it could wrap.
    always_comb begin
        hit_sum   = {1'b0, freq_q} + FreqStepW;
        ramp_sum  = {1'b0, freq_q} + {{FREQ_W{1'b0}}, 1'b1};
        hit_freq  = (hit_sum > FreqMaxW) ? FreqMax : hit_sum[FREQ_W-1:0];
        ramp_freq = (ramp_sum > FreqMaxW) ? FreqMax : ramp_sum[FREQ_W-1:0];
        ramp_done = ((32'(ramp_cnt_q) + 32'd1) >= RAMP_TICKS);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            freq_q       <= '0;
            saved_freq_q <= '0;
            move_en_q    <= 1'b0;
            hit_count_q  <= '0;
            serve_cnt_q  <= '0;
            ramp_cnt_q   <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (bus.start) begin
                        state_q     <= StServe;
                        serve_cnt_q <= ServeLoad;
                    end
                end
                StServe: begin
                    // A zero count (SERVE_TICKS == 0) launches without waiting for a tick.
                    if (serve_cnt_q == '0 || (bus.frame_tick && serve_cnt_q == ServeOne)) begin
                        state_q     <= StPlay;
                        freq_q      <= FreqStart;
                        move_en_q   <= 1'b1;
                        hit_count_q <= '0;
                        ramp_cnt_q  <= '0;
                        serve_cnt_q <= '0;
                    end else if (bus.frame_tick) begin
                        serve_cnt_q <= serve_cnt_q - ServeOne;
                    end
                end
                StPlay: begin
                    if (bus.goal) begin
                        state_q     <= StServe;
                        freq_q      <= '0;
                        move_en_q   <= 1'b0;
                        hit_count_q <= '0;
                        serve_cnt_q <= ServeLoad;
                    end else if (bus.pause) begin
                        state_q      <= StPause;
                        saved_freq_q <= freq_q;
                        freq_q       <= '0;
                        move_en_q    <= 1'b0;
                    end else if (bus.paddle_hit) begin
                        freq_q      <= hit_freq;
                        hit_count_q <= (hit_count_q == 8'hff) ? hit_count_q : hit_count_q + 8'd1;
                        ramp_cnt_q  <= '0;
                    end else if (bus.frame_tick) begin
                        if (ramp_done) begin
                            freq_q     <= ramp_freq;
                            ramp_cnt_q <= '0;
                        end else begin
                            ramp_cnt_q <= ramp_cnt_q + RAMP_W'(1);
                        end
                    end
                end
                StPause: begin
                    if (bus.pause) begin
                        state_q   <= StPlay;
                        freq_q    <= saved_freq_q;
                        move_en_q <= 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.strobe_freq = freq_q;
    assign bus.move_en     = move_en_q;
    assign bus.state       = state_q;
    assign bus.hit_count   = hit_count_q;
endmodule

// File: tb/tb_ball_speed_sched.sv
// Scenario bench for ball_speed_sched: expected output snapshots are queued as each
// stimulus is driven and popped for comparison one cycle later.
module tb_ball_speed_sched;
    typedef struct packed {
        logic [1:0] st;
        logic [9:0] freq;
        logic       mv;
        logic [7:0] hc;
    } obs_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    obs_t exp_q[$];

    always #5 clk = ~clk;

    ball_speed_sched_if #(.FREQ_W(10)) ifc ();

    ball_speed_sched #(
        .FREQ_W(10), .FREQ_START(60), .FREQ_MAX(600), .FREQ_STEP(20),
        .SERVE_TICKS(120), .RAMP_TICKS(300)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc.slave)
    );

    function automatic obs_t mk(input int st, input int f, input int mv, input int hc);
        obs_t o;
        o.st   = 2'(st);
        o.freq = 10'(f);
        o.mv   = 1'(mv);
        o.hc   = 8'(hc);
        return o;
    endfunction

    function automatic obs_t observe();
        obs_t o;
        o.st   = ifc.state;
        o.freq = ifc.strobe_freq;
        o.mv   = ifc.move_en;
        o.hc   = ifc.hit_count;
        return o;
    endfunction

    function automatic string fmt(input obs_t o);
        return $sformatf("state=%0d freq=%0d move_en=%0d hits=%0d", o.st, o.freq, o.mv, o.hc);
    endfunction

    // One clock: inputs applied at the falling edge, outputs settle #1 after the rise.
    task automatic step(input logic tk, input logic st, input logic hit, input logic gl,
                        input logic ps);
        @(negedge clk);
        ifc.frame_tick = tk;
        ifc.start      = st;
        ifc.paddle_hit = hit;
        ifc.goal       = gl;
        ifc.pause      = ps;
        @(posedge clk);
        #1;
        ifc.frame_tick = 1'b0;
        ifc.start      = 1'b0;
        ifc.paddle_hit = 1'b0;
        ifc.goal       = 1'b0;
        ifc.pause      = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        obs_t got, exp;
        rst = 1'b1;
        exp_q.push_back(mk(0, 0, 0, 0));
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        got = observe(); exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin
            errors++; $display("FAIL reset: got %s want %s", fmt(got), fmt(exp));
        end
        exp_q.push_back(mk(0, 0, 0, 0));
        step(1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
        got = observe(); exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin
            errors++; $display("FAIL idle_ignore: got %s want %s", fmt(got), fmt(exp));
        end
    endtask

    task automatic test_serve();
        obs_t got, exp;
        exp_q.push_back(mk(1, 0, 0, 0));
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        got = observe(); exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin
            errors++; $display("FAIL serve_entry: got %s want %s", fmt(got), fmt(exp));
        end
        exp_q.push_back(mk(1, 0, 0, 0));
        ticks(119);
        got = observe(); exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin
            errors++; $display("FAIL serve_tick119: got %s want %s", fmt(got), fmt(exp));
        end
        exp_q.push_back(mk(2, 60, 1, 0));
        ticks(1);
        got = observe(); exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin
            errors++; $display("FAIL serve_to_play: got %s want %s", fmt(got), fmt(exp));
        end
    endtask

    task automatic test_hits();
        obs_t got, exp;
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(mk(2, 80 + 20 * i, 1, i + 1));
            step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
            got = observe(); exp = exp_q.pop_front(); checks++;
            if (got !== exp) begin
                errors++; $display("FAIL hit%0d: got %s want %s", i + 1, fmt(got), fmt(exp));
            end
        end
        exp_q.push_back(mk(2, 120, 1, 3));
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        got = observe(); exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin
            errors++; $display("FAIL start_in_play: got %s want %s", fmt(got), fmt(exp));
        end
    endtask

    task automatic test_pause();
        obs_t got, exp;
        exp_q.push_back(mk(2, 140, 1, 4));
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        got = observe(); exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin
            errors++; $display("FAIL pre_pause_hit: got %s want %s", fmt(got), fmt(exp));
        end
        exp_q.push_back(mk(3, 0, 0, 4));
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        got = observe(); exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin
            errors++; $display("FAIL pause_enter: got %s want %s", fmt(got), fmt(exp));
        end
        exp_q.push_back(mk(3, 0, 0, 4));
        ticks(500);
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        got = observe(); exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin
            errors++; $display("FAIL pause_hold: got %s want %s", fmt(got), fmt(exp));
        end
        exp_q.push_back(mk(2, 140, 1, 4));
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        got = observe(); exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin
            errors++; $display("FAIL pause_resume: got %s want %s", fmt(got), fmt(exp));
        end
    endtask

    task automatic test_goal_priority();
        obs_t got, exp;
        exp_q.push_back(mk(1, 0, 0, 0));
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        got = observe(); exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin
            errors++; $display("FAIL goal_and_hit: got %s want %s", fmt(got), fmt(exp));
        end
        exp_q.push_back(mk(1, 0, 0, 0));
        ticks(119);
        got = observe(); exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin
            errors++; $display("FAIL reserve_tick119: got %s want %s", fmt(got), fmt(exp));
        end
        exp_q.push_back(mk(2, 60, 1, 0));
        ticks(1);
        got = observe(); exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin
            errors++; $display("FAIL reserve_to_play: got %s want %s", fmt(got), fmt(exp));
        end
    endtask

    task automatic test_ramp();
        obs_t got, exp;
        exp_q.push_back(mk(2, 60, 1, 0));
        ticks(299);
        got = observe(); exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin
            errors++; $display("FAIL ramp_tick299: got %s want %s", fmt(got), fmt(exp));
        end
        exp_q.push_back(mk(2, 61, 1, 0));
        ticks(1);
        got = observe(); exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin
            errors++; $display("FAIL ramp_tick300: got %s want %s", fmt(got), fmt(exp));
        end
    endtask

    task automatic test_saturation();
        obs_t got, exp;
        // 61 + 26*20 = 581, then nine ramp steps reach 590.
        exp_q.push_back(mk(2, 581, 1, 26));
        for (int i = 0; i < 26; i++) step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        got = observe(); exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin
            errors++; $display("FAIL hits_to_581: got %s want %s", fmt(got), fmt(exp));
        end
        exp_q.push_back(mk(2, 590, 1, 26));
        ticks(2700);
        got = observe(); exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin
            errors++; $display("FAIL ramp_to_590: got %s want %s", fmt(got), fmt(exp));
        end
        for (int i = 0; i < 2; i++) begin
            exp_q.push_back(mk(2, 600, 1, 27 + i));
            step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
            got = observe(); exp = exp_q.pop_front(); checks++;
            if (got !== exp) begin
                errors++; $display("FAIL clamp_hit%0d: got %s want %s", i + 1, fmt(got), fmt(exp));
            end
        end
        exp_q.push_back(mk(2, 600, 1, 255));
        for (int i = 0; i < 240; i++) step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        got = observe(); exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin
            errors++; $display("FAIL hit_count_sat: got %s want %s", fmt(got), fmt(exp));
        end
        exp_q.push_back(mk(2, 600, 1, 255));
        ticks(300);
        got = observe(); exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin
            errors++; $display("FAIL ramp_clamp: got %s want %s", fmt(got), fmt(exp));
        end
    endtask

    task automatic test_reset_mid_play();
        obs_t got, exp;
        rst = 1'b1;
        exp_q.push_back(mk(0, 0, 0, 0));
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        rst = 1'b0;
        got = observe(); exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin
            errors++; $display("FAIL reset_mid_play: got %s want %s", fmt(got), fmt(exp));
        end
    endtask

    initial begin
        ifc.frame_tick = 1'b0;
        ifc.start      = 1'b0;
        ifc.paddle_hit = 1'b0;
        ifc.goal       = 1'b0;
        ifc.pause      = 1'b0;
        test_reset();
        test_serve();
        test_hits();
        test_pause();
        test_goal_priority();
        test_ramp();
        test_saturation();
        test_reset_mid_play();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
